// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Initiator for a combinational ALU. Latches one operand set on an accepted
//   start, drives it onto the ALU, and sweeps Ctrl from 0 to all-ones. For each
//   code it waits SETTLE+1 cycles, samples Output/Cout, and offers the result on
//   a valid/ready stream. A one-cycle done pulse follows the last transfer.
//
//   Ports
//     clk, rst_n                 clock, async active-low reset
//     start, a_in, b_in, cin_in  sweep request and its operands (taken in IDLE only)
//     busy                       high whenever a sweep is in progress
//     alu_a/b/cin/ctrl           registered drive to the ALU
//     alu_out, alu_cout          ALU response
//     res_valid/ready            result stream handshake
//     res_ctrl/data/cout         result payload
//     done                       one-cycle pulse after the final transfer
//     chk_out                    (ALU_SEQ_CHECKSUM_EN only) XOR of every transferred
//                                {res_cout,res_data}, cleared on accepted start
//
//   Optional feature macro: ALU_SEQ_CHECKSUM_EN
module alu_op_sequencer #(
  parameter int DWIDTH = 4,
  parameter int CWIDTH = 3,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DWIDTH-1:0] a_in,
  input  logic [DWIDTH-1:0] b_in,
  input  logic              cin_in,
  output logic              busy,
  output logic [DWIDTH-1:0] alu_a,
  output logic [DWIDTH-1:0] alu_b,
  output logic              alu_cin,
  output logic [CWIDTH-1:0] alu_ctrl,
  input  logic [DWIDTH-1:0] alu_out,
  input  logic              alu_cout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CWIDTH-1:0] res_ctrl,
  output logic [DWIDTH-1:0] res_data,
  output logic              res_cout,
`ifdef ALU_SEQ_CHECKSUM_EN
  output logic [DWIDTH:0]   chk_out,
`endif
  output logic              done
);

  // counter must hold SETTLE; keep at least one bit so SETTLE=0 still elaborates
  localparam int CNTW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VALID, S_DONE} state_t;

  state_t          state, nxt;
  logic [CNTW-1:0] cnt;
  logic            last_ctrl;

  assign last_ctrl = (alu_ctrl == '1);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start)     nxt = S_WAIT;
      S_WAIT:  if (cnt == '0) nxt = S_VALID;
      S_VALID: if (res_ready) nxt = last_ctrl ? S_DONE : S_WAIT;
      S_DONE:                 nxt = S_IDLE;
      default:                nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cin   <= 1'b0;
      alu_ctrl  <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_ctrl  <= '0;
      res_data  <= '0;
      res_cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          alu_a    <= a_in;
          alu_b    <= b_in;
          alu_cin  <= cin_in;
          alu_ctrl <= '0;
          cnt      <= CNTW'(SETTLE);
        end
        S_WAIT: if (cnt == '0) begin
          res_ctrl  <= alu_ctrl;
          res_data  <= alu_out;
          res_cout  <= alu_cout;
          res_valid <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
        // alu_* and res_* hold while stalled; ctrl stops at all-ones, never wraps
        S_VALID: if (res_ready) begin
          res_valid <= 1'b0;
          if (!last_ctrl) begin
            alu_ctrl <= alu_ctrl + 1'b1;
            cnt      <= CNTW'(SETTLE);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               chk_out <= '0;
    else if (state == S_IDLE && start)        chk_out <= '0;
    else if (state == S_VALID && res_ready)   chk_out <= chk_out ^ {res_cout, res_data};
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench: two sequencers (SETTLE=1 and SETTLE=0), each driving a stub ALU
// {cout,out} = a + ctrl. Expected results come from plain arithmetic on the
// latched operand and the sweep index.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_s [2];
  logic [3:0] a_s [2];
  logic [3:0] b_s [2];
  logic       cin_s [2];
  logic       ready_s [2];

  logic       busy_w [2];
  logic [3:0] alu_a_w [2];
  logic [3:0] alu_b_w [2];
  logic       alu_cin_w [2];
  logic [2:0] alu_ctrl_w [2];
  logic [3:0] alu_out_w [2];
  logic       alu_cout_w [2];
  logic       res_valid_w [2];
  logic [2:0] res_ctrl_w [2];
  logic [3:0] res_data_w [2];
  logic       res_cout_w [2];
  logic       done_w [2];
`ifdef ALU_SEQ_CHECKSUM_EN
  logic [4:0] chk_out_w [2];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {alu_cout_w[0], alu_out_w[0]} = {1'b0, alu_a_w[0]} + {2'b00, alu_ctrl_w[0]};
  assign {alu_cout_w[1], alu_out_w[1]} = {1'b0, alu_a_w[1]} + {2'b00, alu_ctrl_w[1]};

  alu_op_sequencer #(.DWIDTH(4), .CWIDTH(3), .SETTLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .a_in(a_s[0]), .b_in(b_s[0]),
    .cin_in(cin_s[0]), .busy(busy_w[0]), .alu_a(alu_a_w[0]), .alu_b(alu_b_w[0]),
    .alu_cin(alu_cin_w[0]), .alu_ctrl(alu_ctrl_w[0]), .alu_out(alu_out_w[0]),
    .alu_cout(alu_cout_w[0]), .res_valid(res_valid_w[0]), .res_ready(ready_s[0]),
    .res_ctrl(res_ctrl_w[0]), .res_data(res_data_w[0]), .res_cout(res_cout_w[0]),
`ifdef ALU_SEQ_CHECKSUM_EN
    .chk_out(chk_out_w[0]),
`endif
    .done(done_w[0]));

  alu_op_sequencer #(.DWIDTH(4), .CWIDTH(3), .SETTLE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .a_in(a_s[1]), .b_in(b_s[1]),
    .cin_in(cin_s[1]), .busy(busy_w[1]), .alu_a(alu_a_w[1]), .alu_b(alu_b_w[1]),
    .alu_cin(alu_cin_w[1]), .alu_ctrl(alu_ctrl_w[1]), .alu_out(alu_out_w[1]),
    .alu_cout(alu_cout_w[1]), .res_valid(res_valid_w[1]), .res_ready(ready_s[1]),
    .res_ctrl(res_ctrl_w[1]), .res_data(res_data_w[1]), .res_cout(res_cout_w[1]),
`ifdef ALU_SEQ_CHECKSUM_EN
    .chk_out(chk_out_w[1]),
`endif
    .done(done_w[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag, input int i);
    check({tag, "_busy"},  busy_w[i],      0);
    check({tag, "_vld"},   res_valid_w[i], 0);
    check({tag, "_done"},  done_w[i],      0);
    check({tag, "_alua"},  alu_a_w[i],     0);
    check({tag, "_alub"},  alu_b_w[i],     0);
    check({tag, "_cin"},   alu_cin_w[i],   0);
    check({tag, "_ctrl"},  alu_ctrl_w[i],  0);
    check({tag, "_rctrl"}, res_ctrl_w[i],  0);
    check({tag, "_rdata"}, res_data_w[i],  0);
    check({tag, "_rcout"}, res_cout_w[i],  0);
`ifdef ALU_SEQ_CHECKSUM_EN
    check({tag, "_chk"},   chk_out_w[i],   0);
`endif
  endtask

  // mode 0: ready held high; mode 1: random ready every cycle.
  // stall_k: hold ready low 5 cycles when that result is offered (-1 = never).
  // probe: pulse start with a_in=0 mid-sweep. rst_at: assert reset while that result is offered.
  task automatic sweep(input int i, input logic [3:0] a, input int mode,
                       input int stall_k, input int probe, input int rst_at);
    int settle, t, k, st, e;
    bit seen, r;
    logic [4:0] xs;
    settle = (i == 0) ? 1 : 0;
    @(negedge clk);
    a_s[i] = a; b_s[i] = 4'($urandom); cin_s[i] = 1'($urandom);
    start_s[i] = 1'b1; ready_s[i] = 1'b0;
    @(negedge clk);
    start_s[i] = 1'b0;
    check("busy_on", busy_w[i], 1);
    check("lat_a", alu_a_w[i], a);
    check("lat_b", alu_b_w[i], b_s[i]);
    check("lat_cin", alu_cin_w[i], cin_s[i]);
    check("ctrl0", alu_ctrl_w[i], 0);
`ifdef ALU_SEQ_CHECKSUM_EN
    check("chk_clr", chk_out_w[i], 0);
`endif
    t = 0; k = 0; st = 0; seen = 0; xs = '0;
    while (k < 8 && t < 300) begin
      if (probe != 0 && t == 3) begin start_s[i] = 1'b1; a_s[i] = 4'b0000; end
      else start_s[i] = 1'b0;
      if (res_valid_w[i]) begin
        e = int'(a) + k;
        if (!seen) begin
          check("res_ctrl", res_ctrl_w[i], k);
          check("res_data", res_data_w[i], e & 15);
          check("res_cout", res_cout_w[i], (e >> 4) & 1);
          if (k == 0) check("latency", t, settle + 1);
          seen = 1;
        end else begin
          check("hold_ctrl", res_ctrl_w[i], k);
          check("hold_data", res_data_w[i], e & 15);
          check("hold_alu", alu_ctrl_w[i], k);
        end
        if (k == rst_at) begin
          ready_s[i] = 1'b0;
          #2 rst_n = 1'b0;
          #1 check_idle("rst_mid", i);
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        if (k == stall_k && st < 5) begin r = 0; st++; end
        else r = (mode == 1) ? 1'($urandom) : 1'b1;
        ready_s[i] = r;
        if (r) begin xs = xs ^ 5'(e); k++; seen = 0; end
      end else begin
        check("done_early", done_w[i], 0);
        ready_s[i] = (mode == 1) ? 1'($urandom) : 1'b1;
      end
      @(negedge clk);
      t++;
    end
    start_s[i] = 1'b0;
    check("timeout", (t >= 300) ? 1 : 0, 0);
    check("done", done_w[i], 1);
    check("done_vld", res_valid_w[i], 0);
    if (mode == 0 && stall_k < 0) check("sweep_len", t, 8 * (settle + 2));
`ifdef ALU_SEQ_CHECKSUM_EN
    check("chk_done", chk_out_w[i], xs);
`endif
    ready_s[i] = 1'b0;
    @(negedge clk);
    check("done_pulse", done_w[i], 0);
    check("busy_off", busy_w[i], 0);
    check("keep_ctrl", alu_ctrl_w[i], 7);
    check("keep_a", alu_a_w[i], a);
`ifdef ALU_SEQ_CHECKSUM_EN
    check("chk_keep", chk_out_w[i], xs);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 0; a_s[i] = 0; b_s[i] = 0; cin_s[i] = 0; ready_s[i] = 0;
    end
    repeat (3) @(negedge clk);
    check_idle("reset0", 0);
    check_idle("reset1", 1);
    rst_n = 1'b1;

    sweep(0, 4'b1010, 0, -1, 0, -1);   // plain sweep, ready tied high
    sweep(0, 4'b1010, 0,  3, 0, -1);   // backpressure at ctrl 3
    sweep(0, 4'b1010, 0, -1, 1, -1);   // start while busy must be ignored
    sweep(0, 4'b1010, 0, -1, 0,  4);   // async reset mid-sweep
    sweep(0, 4'b1010, 0, -1, 0, -1);   // restarts from ctrl 0
    sweep(1, 4'($urandom), 0, -1, 0, -1);  // SETTLE=0 timing
    sweep(0, 4'b0011, 0, -1, 0, -1);
`ifdef ALU_SEQ_CHECKSUM_EN
    check("chk_0011", chk_out_w[0], 5'b01000);
`endif
    for (int j = 0; j < 6; j++)
      sweep(j % 2, 4'($urandom), 1, (j == 2) ? int'($urandom_range(0, 7)) : -1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
